spi_sample_scheduler: RTL and testbench

Receives 16-bit tagged control words from the Arduino over SPI and oversamples the SPI pins in the `CLK_50Mhz` domain. Decodes each word into a frequency, amplitude or mute update, holds it as pending, and commits all pending updates together on the next audio sample tick. The tone generator therefore never sees a half-applied frequency/amplitude pair. It sits between the Arduino header pins and the sample-rate synthesis datapath.

---
 rtl/spi_music_pkg.sv | 19 +
 rtl/spi_pin_sync.sv | 49 ++++
 rtl/spi_sample_scheduler.sv | 141 ++++++++++++++
 tb/tb_spi_sample_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_music_pkg.sv
// Shared types and constants for the SPI control-word scheduler.
// Tags select which pending field a received word updates.
package spi_music_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DECODE
  } spi_sched_state_t;

  localparam logic [1:0] TAG_FREQ = 2'b01;
  localparam logic [1:0] TAG_AMP  = 2'b10;
  localparam logic [1:0] TAG_MUTE = 2'b11;

  localparam int FRAME_BITS = 16;
  localparam int FREQ_W     = 14;
  localparam int AMP_W      = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Synchronizes the three SPI pins into CLK_50Mhz and flags SCLK/CS edges.
// Sync chains run free so a CS held low across reset yields no false edge.
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sclkPin,
  input  logic csPin,
  input  logic sdoPin,
  output logic csSync,
  output logic sdoSync,
  output logic sclkRise,
  output logic csFall,
  output logic csRise
);

  logic [SYNC_STAGES-1:0] sclkPipe;
  logic [SYNC_STAGES-1:0] csPipe;
  logic [SYNC_STAGES-1:0] sdoPipe;
  logic                   sclkSync;
  logic                   sclkPrev;
  logic                   csPrev;

  always_ff @(posedge clk) begin
    sclkPipe <= {sclkPipe[SYNC_STAGES-2:0], sclkPin};
    csPipe   <= {csPipe[SYNC_STAGES-2:0], csPin};
    sdoPipe  <= {sdoPipe[SYNC_STAGES-2:0], sdoPin};
    sclkPrev <= sclkSync;
    csPrev   <= csSync;
  end

  assign sclkSync = sclkPipe[SYNC_STAGES-1];
  assign csSync   = csPipe[SYNC_STAGES-1];
  assign sdoSync  = sdoPipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      sclkRise <= 1'b0;
      csFall   <= 1'b0;
      csRise   <= 1'b0;
    end else begin
      sclkRise <= sclkSync & ~sclkPrev;
      csFall   <= ~csSync & csPrev;
      csRise   <= csSync & ~csPrev;
    end
  end

endmodule

// File: rtl/spi_sample_scheduler.sv
// Receives tagged SPI control words and commits pending updates
// atomically on the audio sample tick.
module spi_sample_scheduler
  import spi_music_pkg::*;
#(
  parameter int         SYNC_STAGES       = 2,
  parameter logic [7:0] DEFAULT_AMPLITUDE = 8'd0
) (
  input  logic              CLK_50Mhz,
  input  logic              reset,
  input  logic              sampleTick,
  input  logic              input_SPI_SCLK,
  input  logic              input_SPI_CS_n,
  input  logic              input_SPI_SDO,
  output logic [FREQ_W-1:0] outputFrequencySample,
  output logic [AMP_W-1:0]  outputAmplitudeSample,
  output logic              outputMute,
  output logic              updateStrobe,
  output logic              inputLight,
  output logic [7:0]        frameErrorCount
);

  logic csSync, sdoSync, sclkRise, csFall, csRise;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (CLK_50Mhz),
    .reset   (reset),
    .sclkPin (input_SPI_SCLK),
    .csPin   (input_SPI_CS_n),
    .sdoPin  (input_SPI_SDO),
    .csSync  (csSync),
    .sdoSync (sdoSync),
    .sclkRise(sclkRise),
    .csFall  (csFall),
    .csRise  (csRise)
  );

  assign inputLight = ~csSync;

  spi_sched_state_t        state, stateNext;
  logic [FRAME_BITS-1:0]   shift;
  logic [4:0]              bitCount;
  logic [FREQ_W-1:0]       pendFreq;
  logic [AMP_W-1:0]        pendAmp;
  logic                    pendMute;
  logic                    pendFreqV, pendAmpV, pendMuteV;
  logic                    wrFreq, wrAmp, wrMute, badFrame;
  logic [1:0]              tag;

  assign tag = shift[FRAME_BITS-1 -: 2];

  always_comb begin
    stateNext = state;
    wrFreq    = 1'b0;
    wrAmp     = 1'b0;
    wrMute    = 1'b0;
    badFrame  = 1'b0;
    unique case (state)
      IDLE:    if (csFall) stateNext = SHIFT;
      SHIFT:   if (csRise) stateNext = DECODE;
      DECODE: begin
        stateNext = IDLE;
        if (bitCount != 5'(FRAME_BITS)) begin
          badFrame = 1'b1;
        end else begin
          wrFreq   = (tag == TAG_FREQ);
          wrAmp    = (tag == TAG_AMP);
          wrMute   = (tag == TAG_MUTE);
          badFrame = (tag == 2'b00);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK_50Mhz) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_ff @(posedge CLK_50Mhz) begin
    if (reset) begin
      shift                 <= '0;
      bitCount              <= '0;
      pendFreq              <= '0;
      pendAmp               <= '0;
      pendMute              <= 1'b0;
      pendFreqV             <= 1'b0;
      pendAmpV              <= 1'b0;
      pendMuteV             <= 1'b0;
      outputFrequencySample <= '0;
      outputAmplitudeSample <= DEFAULT_AMPLITUDE;
      outputMute            <= 1'b0;
      updateStrobe          <= 1'b0;
      frameErrorCount       <= '0;
    end else begin
      if (state == IDLE && csFall) begin
        shift    <= '0;
        bitCount <= '0;
      end else if (state == SHIFT && !csRise && sclkRise) begin
        shift <= {shift[FRAME_BITS-2:0], sdoSync};
        if (bitCount != 5'd17) bitCount <= bitCount + 5'd1;
      end

      updateStrobe <= sampleTick & (pendFreqV | pendAmpV | pendMuteV);
      if (sampleTick) begin
        if (pendFreqV) begin
          outputFrequencySample <= pendFreq;
          pendFreqV             <= 1'b0;
        end
        if (pendAmpV) begin
          outputAmplitudeSample <= pendAmp;
          pendAmpV              <= 1'b0;
        end
        if (pendMuteV) begin
          outputMute <= pendMute;
          pendMuteV  <= 1'b0;
        end
      end

      // A decode in the tick cycle re-arms its flag after the commit clear
      if (wrFreq) begin
        pendFreq  <= shift[FREQ_W-1:0];
        pendFreqV <= 1'b1;
      end
      if (wrAmp) begin
        pendAmp  <= shift[AMP_W-1:0];
        pendAmpV <= 1'b1;
      end
      if (wrMute) begin
        pendMute  <= shift[0];
        pendMuteV <= 1'b1;
      end
      if (badFrame && frameErrorCount != 8'hFF)
        frameErrorCount <= frameErrorCount + 8'd1;
    end
  end

endmodule

// File: tb/tb_spi_sample_scheduler.sv
// Directed bench for spi_sample_scheduler with a commit scoreboard.
// Expected commits are queued at each tick and popped on updateStrobe.
module tb_spi_sample_scheduler;

  localparam logic [7:0] DEF_AMP = 8'h20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sampleTick = 1'b0;
  logic        sclk = 1'b0;
  logic        cs_n = 1'b1;
  logic        sdo = 1'b0;
  logic [13:0] freqOut;
  logic [7:0]  ampOut;
  logic        muteOut;
  logic        strobe;
  logic        light;
  logic [7:0]  errCount;

  spi_sample_scheduler #(
    .SYNC_STAGES      (2),
    .DEFAULT_AMPLITUDE(DEF_AMP)
  ) dut (
    .CLK_50Mhz            (clk),
    .reset                (reset),
    .sampleTick           (sampleTick),
    .input_SPI_SCLK       (sclk),
    .input_SPI_CS_n       (cs_n),
    .input_SPI_SDO        (sdo),
    .outputFrequencySample(freqOut),
    .outputAmplitudeSample(ampOut),
    .outputMute           (muteOut),
    .updateStrobe         (strobe),
    .inputLight           (light),
    .frameErrorCount      (errCount)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [13:0] f;
    logic [7:0]  a;
    logic        m;
  } commit_t;

  commit_t     sbq[$];
  int          checks = 0;
  int          errors = 0;

  logic [13:0] pF, cF;
  logic [7:0]  pA, cA;
  logic        pM, cM;
  bit          vF, vA, vM;
  int          expErr;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    pF = '0; pA = '0; pM = 1'b0;
    cF = '0; cA = DEF_AMP; cM = 1'b0;
    vF = 0; vA = 0; vM = 0;
    expErr = 0;
  endtask

  task automatic model_frame(input logic [15:0] w, input int n);
    if (n != 16 || w[15:14] == 2'b00) begin
      if (expErr < 255) expErr++;
    end else if (w[15:14] == 2'b01) begin
      pF = w[13:0]; vF = 1;
    end else if (w[15:14] == 2'b10) begin
      pA = w[7:0]; vA = 1;
    end else begin
      pM = w[0]; vM = 1;
    end
  endtask

  task automatic send(input logic [16:0] bits, input int n);
    cs_n = 1'b0;
    cyc(6);
    chk("light_on", 32'(light), 32'd1);
    for (int i = n - 1; i >= 0; i--) begin
      sdo  = bits[i];
      sclk = 1'b0;
      cyc(5);
      sclk = 1'b1;
      cyc(5);
    end
    sclk = 1'b0;
    cyc(5);
    cs_n = 1'b1;
  endtask

  task automatic tick(input string tag);
    bit      exp;
    commit_t e;
    exp = vF | vA | vM;
    if (exp) begin
      if (vF) cF = pF;
      if (vA) cA = pA;
      if (vM) cM = pM;
      vF = 0; vA = 0; vM = 0;
      sbq.push_back({cF, cA, cM});
    end
    sampleTick = 1'b1;
    cyc(1);
    sampleTick = 1'b0;
    chk({tag, "_strobe"}, 32'(strobe), 32'(exp));
    if (strobe) begin
      chk({tag, "_sb_nonempty"}, 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk({tag, "_freq"}, 32'(freqOut), 32'(e.f));
        chk({tag, "_amp"}, 32'(ampOut), 32'(e.a));
        chk({tag, "_mute"}, 32'(muteOut), 32'(e.m));
      end
    end else begin
      chk({tag, "_freq_hold"}, 32'(freqOut), 32'(cF));
      chk({tag, "_amp_hold"}, 32'(ampOut), 32'(cA));
      chk({tag, "_mute_hold"}, 32'(muteOut), 32'(cM));
    end
    cyc(1);
    chk({tag, "_strobe_one"}, 32'(strobe), 32'd0);
    chk({tag, "_errcnt"}, 32'(errCount), 32'(expErr));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_freq"}, 32'(freqOut), 32'd0);
    chk({tag, "_amp"}, 32'(ampOut), 32'(DEF_AMP));
    chk({tag, "_mute"}, 32'(muteOut), 32'd0);
    chk({tag, "_strobe"}, 32'(strobe), 32'd0);
    chk({tag, "_err"}, 32'(errCount), 32'd0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    cyc(6);
    check_reset_vals("rst");
    chk("rst_light", 32'(light), 32'd0);
    reset = 1'b0;
    cyc(4);

    send({1'b0, 16'h4ABC}, 16);
    model_frame(16'h4ABC, 16);
    cyc(8);
    tick("freq");

    send({1'b0, 16'h8055}, 16);
    model_frame(16'h8055, 16);
    cyc(8);
    send({1'b0, 16'h4123}, 16);
    model_frame(16'h4123, 16);
    cyc(8);
    tick("pair");

    send({2'b0, 15'h0ABC}, 15);
    model_frame(16'h0ABC, 15);
    cyc(8);
    send(17'h1_4555, 17);
    model_frame(16'h4555, 17);
    cyc(8);
    chk("short_err", 32'(errCount), 32'd2);
    tick("short");

    send({1'b0, 16'hC001}, 16);
    cyc(4);
    tick("coll_first");
    model_frame(16'hC001, 16);
    cyc(6);
    tick("coll_next");

    send({1'b0, 16'h4001}, 16);
    model_frame(16'h4001, 16);
    cyc(8);
    send({1'b0, 16'h4002}, 16);
    model_frame(16'h4002, 16);
    cyc(8);
    tick("ovw");

    cs_n = 1'b0;
    cyc(6);
    for (int i = 0; i < 4; i++) begin
      sdo = 1'b1; sclk = 1'b1; cyc(5);
      sclk = 1'b0; cyc(5);
    end
    reset = 1'b1;
    cyc(3);
    model_reset();
    check_reset_vals("midrst");
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sdo = i[0]; sclk = 1'b1; cyc(5);
      sclk = 1'b0; cyc(5);
    end
    cs_n = 1'b1;
    cyc(8);
    tick("midrst_idle");
    send({1'b0, 16'h4007}, 16);
    model_frame(16'h4007, 16);
    cyc(8);
    tick("midrst_fresh");

    for (int i = 0; i < 260; i++) begin
      cs_n = 1'b0;
      cyc(6);
      cs_n = 1'b1;
      cyc(8);
      model_frame(16'h0000, 0);
    end
    chk("err_sat", 32'(errCount), 32'(expErr));
    chk("err_sat_255", 32'(errCount), 32'd255);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
